fifo_param: RTL and testbench
=============================

FIFO_PARAM -- requirements
Module: fifo_param

Interface
REQ-001 Parameter DATA_W, default 8, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 16, storage depth in words (power of two, >=2).
REQ-003 Parameter AF_THRESH, default DEPTH-2, almost_full assert level in words.
REQ-004 Parameter AE_THRESH, default 2, almost_empty assert level in words.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 FIFO_reset  input  1  reset, synchronous, active-high.
REQ-007 FIFO_clr  input  1  synchronous active-high flush.
REQ-008 push  input  1  write request.
REQ-009 pop  input  1  read request.
REQ-010 data_in  input  DATA_W  write data.
REQ-011 data_out  output  DATA_W  read data.
REQ-012 full, empty  output  1 each  occupancy == DEPTH / occupancy == 0.
REQ-013 almost_full, almost_empty  output  1 each  threshold flags.
REQ-014 count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-015 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-016 Write accepted when push=1 and (full=0, or full=1 with a pop accepted in the same cycle); the accepted word is stored at wr_ptr and wr_ptr increments modulo DEPTH.
REQ-017 Read accepted when pop=1 and empty=0; rd_ptr increments modulo DEPTH.
REQ-018 count +1 on accepted write only, -1 on accepted read only, unchanged on both or neither.
REQ-019 push & pop on empty: write accepted, read rejected, underflow set, count becomes 1.
REQ-020 push while full without an accepted pop: word dropped, storage unchanged, overflow set.
REQ-021 pop while empty: no state change except underflow set; data_out holds.
REQ-022 overflow/underflow stay 1 until FIFO_reset or FIFO_clr.
REQ-023 full, empty, almost_full (count >= AF_THRESH) and almost_empty (count <= AE_THRESH) are derived combinationally from registered count, so they are valid in the cycle after the edge that changed count.
REQ-024 Priority: FIFO_reset > FIFO_clr > push/pop; push/pop during clear are ignored and do not set error flags.
REQ-025 FIFO_clr for one cycle: pointers, count, data_out and error flags go to 0; memory contents are not required to change.
REQ-026 Ordering is strictly first-in first-out across pointer wrap-around.

Reset
REQ-027 On FIFO_reset=1 at a rising clk edge: pointers=0, count=0, data_out=0, overflow=0, underflow=0, so full=0, empty=1, almost_empty=1, and almost_full=0 (for AF_THRESH>0).
REQ-028 Reset asserted mid-operation discards all stored words; the first accepted read after reset returns the first word written after reset.

Configuration
REQ-029 Macro FIFO_PARAM_FWFT_EN selects the read mode.
REQ-030 Without FIFO_PARAM_FWFT_EN: data_out is registered, loads the head word at the edge accepting a pop (1-cycle read latency), and holds otherwise.
REQ-031 With FIFO_PARAM_FWFT_EN: data_out shows the head word combinationally whenever empty=0, and is 0 when empty=1; pop acknowledges and advances to the next word.

Verification (DATA_W=8, DEPTH=4, AF_THRESH=3, AE_THRESH=1)
REQ-032 Reset, then push 0x11,0x22,0x33,0x44 on consecutive cycles -> full=1, almost_full=1, count=4; then 4 pops -> data_out 0x11,0x22,0x33,0x44 in order, empty=1.
REQ-033 Fill to 4, push 0x55 without pop -> overflow=1, count=4, later reads contain no 0x55.
REQ-034 Fill to 4, push 0x66 with pop -> head 0x11 read, count stays 4, 0x66 read out last.
REQ-035 Empty FIFO, pop -> underflow=1, count=0; push 0x77 & pop together -> count=1, a later pop returns 0x77.
REQ-036 Ten write/read pairs of values 0x00..0x09 -> outputs match in order across wrap-around; almost_empty=1 at count<=1.
REQ-037 With 3 words stored, assert FIFO_clr (then FIFO_reset) for one cycle -> count=0, empty=1, flags=0, data_out=0; run in both macro settings.

Source files
------------

// File: rtl/fifo_param_if.sv
// Handshake/status bundle for fifo_param: flush, push/pop, data and occupancy flags.
interface fifo_param_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic              FIFO_clr;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CW-1:0]     count;
  logic              overflow;
  logic              underflow;

  modport master (
    output FIFO_clr, push, pop, data_in,
    input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  FIFO_clr, push, pop, data_in,
    output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_param.sv
// Single-clock parameterised FIFO with sticky overflow/underflow and threshold flags.
// Define FIFO_PARAM_FWFT_EN for first-word-fall-through reads; default is a registered read.
module fifo_param #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AF_THRESH = DEPTH - 2,
  parameter int unsigned AE_THRESH = 2
) (
  input logic         clk,
  input logic         FIFO_reset,
  fifo_param_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              full, empty;
  logic              wr_acc, rd_acc, mem_we;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // A pop on a full FIFO frees a slot in the same cycle, so the push may proceed.
  assign rd_acc = bus.pop & ~empty;
  assign wr_acc = bus.push & (~full | rd_acc);
  assign mem_we = wr_acc & ~FIFO_reset & ~bus.FIFO_clr;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (bus.FIFO_clr) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (bus.push && full && !rd_acc) overflow_d  = 1'b1;
      if (bus.pop && empty)            underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (FIFO_reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage needs no reset; stale words are never visible once pointers are cleared.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= bus.data_in;
  end

`ifdef FIFO_PARAM_FWFT_EN
  assign bus.data_out = empty ? '0 : mem_q[rd_ptr_q];
`else
  logic [DATA_W-1:0] data_out_q, data_out_d;

  always_comb begin
    data_out_d = data_out_q;
    if (bus.FIFO_clr)  data_out_d = '0;
    else if (rd_acc)   data_out_d = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (FIFO_reset) data_out_q <= '0;
    else            data_out_q <= data_out_d;
  end

  assign bus.data_out = data_out_q;
`endif

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= CW'(AF_THRESH));
  assign bus.almost_empty = (count_q <= CW'(AE_THRESH));
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param (DEPTH=4, AF=3, AE=1): vector table plus corner sequences.
module tb_fifo_param;
  localparam int unsigned DW = 8;
  localparam int unsigned D  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_param_if #(.DATA_W(DW), .DEPTH(D)) bus ();

  fifo_param #(
    .DATA_W   (DW),
    .DEPTH    (D),
    .AF_THRESH(3),
    .AE_THRESH(1)
  ) dut (
    .clk       (clk),
    .FIFO_reset(rst),
    .bus       (bus)
  );

  typedef struct {
    bit       r;
    bit       c;
    bit       p;
    bit       q;
    logic [7:0] din;
    int       cnt;
    bit       ovf;
    bit       udf;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] sb[$];
  int         tests = 0;
  int         fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input bit r, input bit c, input bit p, input bit q, input logic [7:0] din,
                     input int cnt, input bit ovf, input bit udf);
    vec_t v;
    v.r = r; v.c = c; v.p = p; v.q = q; v.din = din;
    v.cnt = cnt; v.ovf = ovf; v.udf = udf;
    vecs.push_back(v);
  endtask

  // One clock of stimulus; the scoreboard predicts and checks read data.
  task automatic step(input bit r, input bit c, input bit p, input bit q, input logic [7:0] d);
    logic [7:0] exp_w;
    int         sz;
    bit         rd;
    bit         wr;
    rst = r; bus.FIFO_clr = c; bus.push = p; bus.pop = q; bus.data_in = d;
    sz = sb.size();
    rd = !r && !c && q && (sz > 0);
    wr = !r && !c && p && ((sz < int'(D)) || rd);
    exp_w = 8'h00;
    if (rd) exp_w = sb.pop_front();
    if (wr) sb.push_back(d);
    if (r || c) sb.delete();
`ifdef FIFO_PARAM_FWFT_EN
    if (rd) begin
      #1;
      check("fwft read data", {24'h0, bus.data_out}, {24'h0, exp_w});
    end
`endif
    @(posedge clk);
    #1;
`ifndef FIFO_PARAM_FWFT_EN
    if (rd) check("read data", {24'h0, bus.data_out}, {24'h0, exp_w});
`endif
  endtask

  task automatic check_flags(input string tag, input int cnt, input bit ovf, input bit udf);
    check({tag, " count"},        {29'h0, bus.count},  cnt);
    check({tag, " full"},         {31'h0, bus.full},   {31'h0, cnt == int'(D)});
    check({tag, " empty"},        {31'h0, bus.empty},  {31'h0, cnt == 0});
    check({tag, " almost_full"},  {31'h0, bus.almost_full},  {31'h0, cnt >= 3});
    check({tag, " almost_empty"}, {31'h0, bus.almost_empty}, {31'h0, cnt <= 1});
    check({tag, " overflow"},     {31'h0, bus.overflow},  {31'h0, ovf});
    check({tag, " underflow"},    {31'h0, bus.underflow}, {31'h0, udf});
  endtask

  initial begin
    // Fill and drain in order.
    add(0, 0, 1, 0, 8'h11, 1, 0, 0); add(0, 0, 1, 0, 8'h22, 2, 0, 0);
    add(0, 0, 1, 0, 8'h33, 3, 0, 0); add(0, 0, 1, 0, 8'h44, 4, 0, 0);
    add(0, 0, 0, 1, 8'h00, 3, 0, 0); add(0, 0, 0, 1, 8'h00, 2, 0, 0);
    add(0, 0, 0, 1, 8'h00, 1, 0, 0); add(0, 0, 0, 1, 8'h00, 0, 0, 0);
    // Push with pop while full.
    add(0, 0, 1, 0, 8'h11, 1, 0, 0); add(0, 0, 1, 0, 8'h22, 2, 0, 0);
    add(0, 0, 1, 0, 8'h33, 3, 0, 0); add(0, 0, 1, 0, 8'h44, 4, 0, 0);
    add(0, 0, 1, 1, 8'h66, 4, 0, 0);
    add(0, 0, 0, 1, 8'h00, 3, 0, 0); add(0, 0, 0, 1, 8'h00, 2, 0, 0);
    add(0, 0, 0, 1, 8'h00, 1, 0, 0); add(0, 0, 0, 1, 8'h00, 0, 0, 0);
    // Overflow: 0x55 dropped.
    add(0, 0, 1, 0, 8'h11, 1, 0, 0); add(0, 0, 1, 0, 8'h22, 2, 0, 0);
    add(0, 0, 1, 0, 8'h33, 3, 0, 0); add(0, 0, 1, 0, 8'h44, 4, 0, 0);
    add(0, 0, 1, 0, 8'h55, 4, 1, 0);
    add(0, 0, 0, 1, 8'h00, 3, 1, 0); add(0, 0, 0, 1, 8'h00, 2, 1, 0);
    add(0, 0, 0, 1, 8'h00, 1, 1, 0); add(0, 0, 0, 1, 8'h00, 0, 1, 0);
    // Underflow, then push+pop on empty.
    add(0, 0, 0, 1, 8'h00, 0, 1, 1);
    add(0, 0, 1, 1, 8'h77, 1, 1, 1);
    add(0, 0, 0, 1, 8'h00, 0, 1, 1);
    // Reset, then ten values across pointer wrap.
    add(1, 0, 0, 0, 8'h00, 0, 0, 0);
    add(0, 0, 1, 0, 8'h00, 1, 0, 0);
    for (int i = 1; i < 10; i++) add(0, 0, 1, 1, 8'(i), 1, 0, 0);
    add(0, 0, 0, 1, 8'h00, 0, 0, 0);

    rst = 1'b1; bus.FIFO_clr = 1'b0; bus.push = 1'b0; bus.pop = 1'b0; bus.data_in = 8'h00;
    @(posedge clk);
    #1;
    check_flags("reset", 0, 0, 0);
    check("reset data_out", {24'h0, bus.data_out}, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].r, vecs[i].c, vecs[i].p, vecs[i].q, vecs[i].din);
      check_flags($sformatf("row%0d", i), vecs[i].cnt, vecs[i].ovf, vecs[i].udf);
    end

    // Flush with 3 words stored and push/pop asserted alongside; both are ignored.
    step(0, 0, 0, 1, 8'h00);
    step(0, 0, 1, 0, 8'ha1); step(0, 0, 1, 0, 8'ha2);
    step(0, 0, 1, 0, 8'ha3); step(0, 0, 1, 0, 8'ha4);
    step(0, 0, 0, 1, 8'h00);
    check_flags("pre-clr", 3, 0, 1);
    step(0, 1, 1, 1, 8'hee);
    check_flags("clr", 0, 0, 0);
    check("clr data_out", {24'h0, bus.data_out}, 32'h0);
    step(0, 0, 1, 0, 8'h5a);
    step(0, 0, 0, 1, 8'h00);
    step(0, 0, 0, 1, 8'h00);
`ifdef FIFO_PARAM_FWFT_EN
    check("pop-empty data_out", {24'h0, bus.data_out}, 32'h0);
`else
    check("pop-empty data_out hold", {24'h0, bus.data_out}, 32'h5a);
`endif
    check_flags("pop-empty", 0, 0, 1);

    // Reset mid-operation discards stored words.
    step(0, 0, 1, 0, 8'hb1); step(0, 0, 1, 0, 8'hb2);
    step(0, 0, 1, 0, 8'hb3); step(0, 0, 1, 0, 8'hb4);
    step(0, 0, 1, 0, 8'hb5);
    step(0, 0, 0, 1, 8'h00);
    check_flags("pre-reset", 3, 1, 1);
    step(1, 0, 1, 1, 8'hcc);
    check_flags("mid reset", 0, 0, 0);
    check("mid reset data_out", {24'h0, bus.data_out}, 32'h0);
    step(0, 0, 1, 0, 8'hc1); step(0, 0, 1, 0, 8'hc2);
    step(0, 0, 0, 1, 8'h00); step(0, 0, 0, 1, 8'h00);
    check_flags("post-reset drain", 0, 0, 0);
    check("scoreboard drained", sb.size(), 32'h0);

    bus.push = 1'b0; bus.pop = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
